// File: rtl/timed_capture_ctrl.sv
// Capture sequencer for the timestamping RX packer: gates the ADC strobe into fifo_wr_en
// between a programmed start timestamp and a programmed sample count.
module timed_capture_ctrl #(
    parameter int unsigned TS_WIDTH         = 64,
    parameter int unsigned COUNT_WIDTH      = 32,
    parameter bit          STOP_ON_OVERFLOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TS_WIDTH-1:0]    timestamp,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   immediate,
    input  logic [TS_WIDTH-1:0]    start_time,
    input  logic [COUNT_WIDTH-1:0] burst_len,
    input  logic                   adc_valid,
    input  logic                   pk_overflow,
    output logic                   pk_fifo_wr_en,
    output logic                   pk_reset,
    output logic                   busy,
    output logic                   capturing,
    output logic                   done,
    output logic                   late,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] sample_count
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   imm_q, imm_d;
    logic [TS_WIDTH-1:0]    start_q, start_d;
    logic [COUNT_WIDTH-1:0] burst_q, burst_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   late_q, late_d;
    logic                   ovf_q, ovf_d;
    logic                   pk_reset_q, pk_reset_d;

    logic                   start_hit;
    logic                   pass;
    logic [COUNT_WIDTH-1:0] count_inc;

    always_comb begin
        state_d    = state_q;
        imm_d      = imm_q;
        start_d    = start_q;
        burst_d    = burst_q;
        count_d    = count_q;
        late_d     = late_q;
        ovf_d      = ovf_q;
        pk_reset_d = 1'b0;
        pass       = 1'b0;

        // No start in the packer-reset cycle, so the header lands on a clean packer.
        start_hit = adc_valid && !pk_reset_q && (imm_q || (timestamp >= start_q));
        count_inc = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);

        unique case (state_q)
            StIdle: begin
                if (arm && !abort) begin
                    imm_d      = immediate;
                    start_d    = start_time;
                    burst_d    = burst_len;
                    count_d    = '0;
                    late_d     = 1'b0;
                    ovf_d      = 1'b0;
                    pk_reset_d = 1'b1;
                    if (!immediate && (timestamp > start_time)) begin
                        late_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StArmed;
                    end
                end
            end
            StArmed: begin
                if (start_hit) begin
                    pass    = 1'b1;
                    count_d = COUNT_WIDTH'(1);
                    state_d = (burst_q == COUNT_WIDTH'(1)) ? StDone : StCapture;
                end
            end
            StCapture: begin
                if (adc_valid) begin
                    pass    = 1'b1;
                    count_d = count_inc;
                    if ((burst_q != '0) && (count_inc == burst_q)) begin
                        state_d = StDone;
                    end
                end
                if (pk_overflow) begin
                    ovf_d = 1'b1;
                    if (STOP_ON_OVERFLOW) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            state_d = StIdle;
            pass    = 1'b0;
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            imm_q      <= 1'b0;
            start_q    <= '0;
            burst_q    <= '0;
            count_q    <= '0;
            late_q     <= 1'b0;
            ovf_q      <= 1'b0;
            pk_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            imm_q      <= imm_d;
            start_q    <= start_d;
            burst_q    <= burst_d;
            count_q    <= count_d;
            late_q     <= late_d;
            ovf_q      <= ovf_d;
            pk_reset_q <= pk_reset_d;
        end
    end

    assign pk_fifo_wr_en = pass && !reset;
    assign pk_reset      = pk_reset_q;
    assign busy          = (state_q != StIdle);
    assign capturing     = (state_q == StCapture);
    assign done          = (state_q == StDone);
    assign late          = late_q;
    assign overflow      = ovf_q;
    assign sample_count  = count_q;

endmodule

// File: tb/tb_timed_capture_ctrl.sv
// Bench for timed_capture_ctrl: expected pass timestamps are queued as stimulus is driven
// and popped whenever the DUT raises pk_fifo_wr_en.
module tb_timed_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset, arm, abort, immediate, adc_valid, pk_overflow;
    logic [63:0] timestamp, start_time;
    logic [31:0] burst_len;

    logic        wr_en0, pk_reset0, busy0, capturing0, done0, late0, overflow0;
    logic [31:0] count0;
    logic        wr_en1, pk_reset1, busy1, capturing1, done1, late1, overflow1;
    logic [31:0] count1;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          pkr_cnt = 0;
    int          pass1_cnt = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    timed_capture_ctrl #(.TS_WIDTH(64), .COUNT_WIDTH(32), .STOP_ON_OVERFLOW(1'b1)) dut0 (
        .clk(clk), .reset(reset), .timestamp(timestamp), .arm(arm), .abort(abort),
        .immediate(immediate), .start_time(start_time), .burst_len(burst_len),
        .adc_valid(adc_valid), .pk_overflow(pk_overflow), .pk_fifo_wr_en(wr_en0),
        .pk_reset(pk_reset0), .busy(busy0), .capturing(capturing0), .done(done0),
        .late(late0), .overflow(overflow0), .sample_count(count0)
    );

    timed_capture_ctrl #(.TS_WIDTH(64), .COUNT_WIDTH(32), .STOP_ON_OVERFLOW(1'b0)) dut1 (
        .clk(clk), .reset(reset), .timestamp(timestamp), .arm(arm), .abort(abort),
        .immediate(immediate), .start_time(start_time), .burst_len(burst_len),
        .adc_valid(adc_valid), .pk_overflow(pk_overflow), .pk_fifo_wr_en(wr_en1),
        .pk_reset(pk_reset1), .busy(busy1), .capturing(capturing1), .done(done1),
        .late(late1), .overflow(overflow1), .sample_count(count1)
    );

    // One clock: sample outputs mid-cycle, then advance past the edge and bump the timestamp.
    task automatic tick();
        logic [63:0] exp_ts;
        @(negedge clk);
        if (wr_en0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pass_unexpected: got pass at ts=%0d, required no pass", timestamp);
            end else begin
                exp_ts = sb.pop_front();
                if (timestamp !== exp_ts) begin
                    errors++;
                    $display("FAIL pass_ts: got %0d, required %0d", timestamp, exp_ts);
                end
            end
        end
        if (done0) done_cnt++;
        if (pk_reset0) pkr_cnt++;
        if (wr_en1) pass1_cnt++;
        @(posedge clk);
        #1;
        timestamp = timestamp + 64'd1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b1; adc_valid = 1'b1; immediate = 1'b1; burst_len = 32'd3;
        tick();
        tick();
        checks++;
        if ({wr_en0, pk_reset0, busy0, capturing0, done0, late0, overflow0} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {wr_en0, pk_reset0, busy0, capturing0, done0, late0, overflow0});
        end
        checks++;
        if (count0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", count0);
        end
        reset = 1'b0; arm = 1'b0; adc_valid = 1'b0;
        tick();
    endtask

    task automatic test_immediate();
        immediate = 1'b1; burst_len = 32'd4; adc_valid = 1'b1;
        done_cnt = 0; pkr_cnt = 0;
        arm_pulse();
        checks++;
        if (pk_reset0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL imm_pk_reset: got pk_reset=%b busy=%b, required 1 1", pk_reset0, busy0);
        end
        for (int i = 1; i <= 4; i++) sb.push_back(timestamp + 64'(i));
        repeat (8) tick();
        checks++;
        if (done_cnt != 1 || pkr_cnt != 1) begin
            errors++;
            $display("FAIL imm_done: got done=%0d pk_reset=%0d, required 1 1", done_cnt, pkr_cnt);
        end
        checks++;
        if (count0 !== 32'd4 || busy0 !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL imm_count: got count=%0d busy=%b pending=%0d, required 4 0 0",
                     count0, busy0, sb.size());
        end
        adc_valid = 1'b0;
    endtask

    task automatic test_start_time();
        int n = 0;
        immediate = 1'b0; start_time = 64'd1000; burst_len = 32'd3;
        timestamp = 64'd900; adc_valid = 1'b0; done_cnt = 0;
        arm_pulse();
        repeat (120) begin
            adc_valid = (timestamp[0] == 1'b0);
            if (adc_valid && timestamp >= 64'd1000 && n < 3) begin
                sb.push_back(timestamp);
                n++;
            end
            tick();
        end
        adc_valid = 1'b0;
        checks++;
        if (sb.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL start_passes: got pending=%0d done=%0d, required 0 1",
                     sb.size(), done_cnt);
        end
        checks++;
        if (count0 !== 32'd3 || late0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL start_state: got count=%0d late=%b busy=%b, required 3 0 0",
                     count0, late0, busy0);
        end
    endtask

    task automatic test_late();
        immediate = 1'b0; start_time = 64'd50; timestamp = 64'd60; burst_len = 32'd5;
        adc_valid = 1'b1; done_cnt = 0;
        arm_pulse();
        checks++;
        if (late0 !== 1'b1) begin
            errors++;
            $display("FAIL late_flag: got %b, required 1", late0);
        end
        repeat (4) tick();
        adc_valid = 1'b0;
        checks++;
        if (done_cnt != 1 || busy0 !== 1'b0 || count0 !== 32'd0 || late0 !== 1'b1) begin
            errors++;
            $display("FAIL late_end: got done=%0d busy=%b count=%0d late=%b, required 1 0 0 1",
                     done_cnt, busy0, count0, late0);
        end
    endtask

    task automatic test_overflow();
        immediate = 1'b1; burst_len = 32'd0; adc_valid = 1'b1; pk_overflow = 1'b0;
        done_cnt = 0; pass1_cnt = 0;
        arm_pulse();
        tick();
        for (int i = 1; i <= 10; i++) begin
            sb.push_back(timestamp);
            pk_overflow = (i == 10);
            tick();
        end
        pk_overflow = 1'b0;
        repeat (5) tick();
        checks++;
        if (overflow0 !== 1'b1 || count0 !== 32'd10 || done_cnt != 1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_stop: got ovf=%b count=%0d done=%0d busy=%b, required 1 10 1 0",
                     overflow0, count0, done_cnt, busy0);
        end
        checks++;
        if (overflow1 !== 1'b1 || capturing1 !== 1'b1 || count1 !== 32'd15 || pass1_cnt != 15) begin
            errors++;
            $display("FAIL ovf_continue: got ovf=%b cap=%b count=%0d passes=%0d, required 1 1 15 15",
                     overflow1, capturing1, count1, pass1_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; adc_valid = 1'b0;
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_abort_idle: got busy=%b, required 0", busy1);
        end
    endtask

    task automatic test_abort();
        immediate = 1'b1; burst_len = 32'd100; adc_valid = 1'b1; done_cnt = 0;
        arm_pulse();
        tick();
        for (int i = 1; i <= 4; i++) begin
            sb.push_back(timestamp);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        adc_valid = 1'b0;
        checks++;
        if (count0 !== 32'd4 || busy0 !== 1'b0 || done_cnt != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort: got count=%0d busy=%b done=%0d pending=%0d, required 4 0 0 0",
                     count0, busy0, done_cnt, sb.size());
        end
    endtask

    task automatic test_arm_ignored();
        pkr_cnt = 0; done_cnt = 0;
        immediate = 1'b1; burst_len = 32'd2; adc_valid = 1'b1;
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        tick();
        checks++;
        if (pkr_cnt != 0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL arm_abort_idle: got pk_reset=%0d busy=%b, required 0 0", pkr_cnt, busy0);
        end
        burst_len = 32'd6;
        arm_pulse();
        tick();
        for (int i = 1; i <= 6; i++) begin
            sb.push_back(timestamp);
            // Re-arm with different config mid-burst; it must not take effect.
            if (i == 3) begin
                arm = 1'b1; burst_len = 32'd2; immediate = 1'b0; start_time = '1;
            end
            tick();
            arm = 1'b0;
        end
        repeat (3) tick();
        adc_valid = 1'b0;
        checks++;
        if (count0 !== 32'd6 || done_cnt != 1 || pkr_cnt != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL arm_busy: got count=%0d done=%0d pk_reset=%0d pending=%0d, required 6 1 1 0",
                     count0, done_cnt, pkr_cnt, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        done_cnt = 0; adc_valid = 1'b1;
        immediate = 1'b0; burst_len = 32'd1; start_time = timestamp;
        arm_pulse();
        checks++;
        if (late0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_not_late: got %b, required 0", late0);
        end
        sb.push_back(timestamp + 64'd1);
        repeat (3) tick();
        immediate = 1'b1; burst_len = 32'd2;
        arm_pulse();
        sb.push_back(timestamp + 64'd1);
        sb.push_back(timestamp + 64'd2);
        repeat (5) tick();
        adc_valid = 1'b0;
        checks++;
        if (done_cnt != 2 || count0 !== 32'd2 || sb.size() != 0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b: got done=%0d count=%0d pending=%0d busy=%b, required 2 2 0 0",
                     done_cnt, count0, sb.size(), busy0);
        end
    endtask

    task automatic test_reset_mid();
        immediate = 1'b1; burst_len = 32'd0; adc_valid = 1'b1;
        arm_pulse();
        tick();
        for (int i = 1; i <= 3; i++) begin
            sb.push_back(timestamp);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; adc_valid = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || count0 !== 32'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b count=%0d pending=%0d, required 0 0 0",
                     busy0, count0, sb.size());
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0; immediate = 1'b0; adc_valid = 1'b0;
        pk_overflow = 1'b0; timestamp = 64'd0; start_time = 64'd0; burst_len = 32'd0;
        test_reset();
        test_immediate();
        test_start_time();
        test_late();
        test_overflow();
        test_abort();
        test_arm_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
